// File: rtl/masked_sbox_sched_pkg.sv
// Shared types for the masked S-box scheduler: requester IDs and the in-flight tag.
package masked_sbox_sched_pkg;

  typedef enum logic {
    REQ_K = 1'b0,
    REQ_S = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '{valid: 1'b0, id: REQ_K};

  // One input register stage in front of the S-box plus its internal stages.
  function automatic int unsigned tag_depth(input int unsigned latency);
    return latency + 1;
  endfunction

endpackage

// File: rtl/masked_sbox_sched_tag_pipe.sv
// Tag shift register that tracks which requester owns each S-box pipeline slot.
module sched_tag_pipe
  import masked_sbox_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic busy_o
);

  tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_o = busy_o | stage_q[i].valid;
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/masked_sbox_sched.sv
// Arbitrates key-expansion and SubBytes requests onto one shared pipelined DOM S-box
// and routes each result back to its requester after a fixed latency.
module masked_sbox_sched
  import masked_sbox_sched_pkg::*;
#(
  parameter int unsigned SHARES  = 2,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned RNDZ_W  = 22,
  parameter int unsigned RNDB_W  = 20
) (
  input  logic                  ClkxCI,
  input  logic                  RstxBI,
  input  logic                  KValidxSI,
  output logic                  KReadyxSO,
  input  logic [8*SHARES-1:0]   KXxDI,
  output logic                  KQValidxSO,
  output logic [8*SHARES-1:0]   KQxDO,
  input  logic                  SValidxSI,
  output logic                  SReadyxSO,
  input  logic [8*SHARES-1:0]   SXxDI,
  output logic                  SQValidxSO,
  output logic [8*SHARES-1:0]   SQxDO,
  input  logic                  RndValidxSI,
  output logic                  RndReadyxSO,
  input  logic [RNDZ_W-1:0]     RndZxDI,
  input  logic [RNDB_W-1:0]     RndBxDI,
  output logic [8*SHARES-1:0]   SboxXxDO,
  output logic [RNDZ_W-1:0]     SboxRandomZxDO,
  output logic [RNDB_W-1:0]     SboxRandomBxDO,
  input  logic [8*SHARES-1:0]   SboxQxDI,
  output logic                  BusyxSO,
  output logic                  RndErrxSO
);

  localparam int unsigned W     = 8 * SHARES;
  localparam int unsigned DEPTH = tag_depth(LATENCY);

  // Handshake: a request transfers in any cycle where Valid && Ready; the requester
  // holds X stable while Valid && !Ready. Results have no backpressure: QValid is a
  // one-cycle pulse that the requester must sink.

  logic              issue;
  req_id_e           grant_id;
  req_id_e           rr_q, rr_d;
  logic [W-1:0]      sbox_x_q, sbox_x_d;
  logic [RNDZ_W-1:0] rndz_q, rndz_d;
  logic [RNDB_W-1:0] rndb_q, rndb_d;
  logic              err_q, err_d;
  tag_t              tag_in, tag_last;
  logic              busy;

  always_comb begin
    issue    = RstxBI & RndValidxSI & (KValidxSI | SValidxSI);
    grant_id = REQ_K;
    if (KValidxSI && SValidxSI) begin
      grant_id = rr_q;
    end else if (SValidxSI) begin
      grant_id = REQ_S;
    end

    rr_d     = rr_q;
    sbox_x_d = '0;
    tag_in   = TAG_BUBBLE;
    if (issue) begin
      rr_d     = (grant_id == REQ_K) ? REQ_S : REQ_K;
      sbox_x_d = (grant_id == REQ_K) ? KXxDI : SXxDI;
      tag_in   = '{valid: 1'b1, id: grant_id};
    end

    // Randomness is forwarded whenever present so in-flight DOM stages keep refreshing.
    rndz_d = RndValidxSI ? RndZxDI : '0;
    rndb_d = RndValidxSI ? RndBxDI : '0;
    err_d  = err_q | (busy & ~RndValidxSI);
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      rr_q     <= REQ_K;
      sbox_x_q <= '0;
      rndz_q   <= '0;
      rndb_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      sbox_x_q <= sbox_x_d;
      rndz_q   <= rndz_d;
      rndb_q   <= rndb_d;
      err_q    <= err_d;
    end
  end

  sched_tag_pipe #(
    .DEPTH(DEPTH)
  ) u_tag_pipe (
    .clk_i (ClkxCI),
    .rst_ni(RstxBI),
    .tag_i (tag_in),
    .tag_o (tag_last),
    .busy_o(busy)
  );

  assign KReadyxSO      = issue & (grant_id == REQ_K);
  assign SReadyxSO      = issue & (grant_id == REQ_S);
  assign RndReadyxSO    = RndValidxSI & (issue | busy);
  assign SboxXxDO       = sbox_x_q;
  assign SboxRandomZxDO = rndz_q;
  assign SboxRandomBxDO = rndb_q;
  assign BusyxSO        = busy;
  assign RndErrxSO      = err_q;

  assign KQValidxSO = tag_last.valid & (tag_last.id == REQ_K);
  assign SQValidxSO = tag_last.valid & (tag_last.id == REQ_S);
  assign KQxDO      = KQValidxSO ? SboxQxDI : '0;
  assign SQxDO      = SQValidxSO ? SboxQxDI : '0;

endmodule

// File: doc/masked_sbox_sched.md
Name: masked_sbox_sched

Overview:
- Shares one pipelined masked (DOM) AES S-box instance between two requesters: key expansion (K) and state SubBytes (S).
- Registers the selected shared byte and its fresh randomness into the S-box and tags each issue with its requester ID.
- Routes each S-box result back to the originating requester after a fixed latency.
- Sits between the round controller and the aes_sbox instance; the S-box itself stays outside this block.

Parameters:
- SHARES, 2, number of Boolean shares per byte.
- LATENCY, 4, S-box input-to-output latency in cycles, for the configured PIPELINED/EIGHT_STAGED setting.
- RNDZ_W, 22, width of the S-box RandomZ bus.
- RNDB_W, 20, width of the S-box RandomB bus.

Ports:
- ClkxCI  in  1  clock.
- RstxBI  in  1  asynchronous reset, active-low.
- KValidxSI  in  1  key-expansion request valid.
- KReadyxSO  out  1  key-expansion request accepted this cycle.
- KXxDI  in  8*SHARES  key-expansion shared input byte.
- KQValidxSO  out  1  key-expansion result valid, one-cycle pulse.
- KQxDO  out  8*SHARES  key-expansion shared result.
- SValidxSI, SReadyxSO, SXxDI, SQValidxSO, SQxDO: same as the K ports, for the state requester.
- RndValidxSI  in  1  fresh randomness available.
- RndReadyxSO  out  1  randomness consumed this cycle.
- RndZxDI  in  RNDZ_W  fresh Z randomness.
- RndBxDI  in  RNDB_W  fresh B randomness.
- SboxXxDO  out  8*SHARES  registered S-box input.
- SboxRandomZxDO  out  RNDZ_W  registered Z randomness to the S-box.
- SboxRandomBxDO  out  RNDB_W  registered B randomness to the S-box.
- SboxQxDI  in  8*SHARES  S-box output.
- BusyxSO  out  1  any operation in flight.
- RndErrxSO  out  1  sticky randomness-starvation error.

Behaviour:
- Reset (RstxBI=0, asynchronous):
  - All registers cleared.
  - Ready, QValid, Busy and RndErr outputs are 0.
  - SboxXxDO and both randomness outputs are 0.
  - Round-robin pointer set to K.
- Request handshake: valid/ready. A requester holds XxDI stable while Valid && !Ready. There is no result backpressure; the requester must sink each QValid pulse.
- Issue condition: issue = RndValidxSI && (KValidxSI || SValidxSI). At most one Ready is high per cycle.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: round-robin; the pointer flips to the other requester after each grant.
  - First contention after reset grants K.
- On issue, at the next edge:
  - SboxXxDO takes the granted XxDI.
  - SboxRandomZxDO/BxDO take RndZxDI/RndBxDI.
  - Tag {valid=1, id} enters tag-pipe stage 0.
- When not issuing, at the next edge:
  - SboxXxDO is zeroed. No mask-carrying value lingers on the S-box input.
  - Randomness outputs take RndZxDI/RndBxDI if RndValidxSI, else zero.
  - A bubble tag {0, x} enters the pipe.
- Randomness consumption: RndReadyxSO = RndValidxSI && (issue || BusyxSO). Later DOM stages consume randomness while ops are in flight, so fresh randomness is drawn every in-flight cycle.
- Starvation: if BusyxSO && !RndValidxSI in any cycle, RndErrxSO sets and stays set until reset. The S-box cannot stall; in-flight results are still delivered.
- Tag pipe:
  - LATENCY+1 stages: one input register plus LATENCY S-box stages.
  - Accept-to-QValid latency is exactly LATENCY+1 cycles.
  - At the last stage with valid=1, the matching requester's QValid pulses for one cycle. KQxDO/SQxDO = SboxQxDI, combinationally registered-free passthrough.
  - The non-matching Q output is driven 0 in that cycle.
- BusyxSO = OR of all tag valid bits.
- Throughput: one issue per cycle sustained. Results return in issue order.
- Simultaneous events: issue and retire in the same cycle are independent.
- Reset mid-operation: the tag pipe clears immediately. No QValid is produced for ops issued before reset.

Decomposition:
- Package masked_sbox_sched_pkg:
  - requester ID enum: REQ_K=0, REQ_S=1.
  - tag struct {valid, id}.
  - function tag_depth(LATENCY) = LATENCY+1.
- Sub-module sched_tag_pipe: a parameterised-depth shift register of tags with asynchronous active-low reset and a Busy OR-reduce.
- The arbiter and the input/randomness registers stay in the top-level block.

Test Plan:
- Reset: hold RstxBI=0 for 3 cycles with all Valid=1 → every output is 0, Ready=0, Busy=0.
- Single K request X=0x53 (shares 0x53^m, m=0xA7), RndValid=1 → KReady=1 in the accept cycle. KQValid pulses exactly 5 cycles later, with XOR of KQ shares = 0xED. SQValid stays 0.
- K and S both valid continuously for 8 cycles, X=0x00 → grants alternate K,S,K,S…. Results (XOR 0x63) return in the same order, one per cycle. Throughput is 8 results in 8 cycles.
- RndValidxSI=0 with requests pending → no Ready, no issue, Busy=0, RndErr stays 0. Raising RndValid issues the request on that cycle.
- Issue one op, then drop RndValidxSI 2 cycles later → RndErrxSO=1 and stays 1. QValid is still delivered at cycle 5.
- Issue 3 ops, then pulse RstxBI low mid-flight → tag pipe empty and Busy=0 immediately. No QValid afterwards.
